// File: rtl/bp_pkg.sv
// Branch-prediction types and widths shared by the fetch PC generator and the
// branch target buffer.
package bp_pkg;

  // Word-address width of a PC, and width of the 8-byte fetch-block address.
  localparam int PC_W  = 30;
  localparam int FPC_W = 29;

  // Branch type stored with each BTB entry.
  typedef enum logic [1:0] {
    BT_JUMP   = 2'd0,
    BT_BRANCH = 2'd1,
    BT_CALL   = 2'd2,
    BT_RET    = 2'd3
  } bt_e;

  // Word address of the first word of the next sequential fetch block.
  // The block-address increment wraps silently at the top of the space.
  function automatic logic [PC_W-1:0] seq_pc(input logic [FPC_W-1:0] fpc);
    return {fpc + FPC_W'(1), 1'b0};
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Speculative circular return-address stack. A push onto a full stack
// overwrites the oldest entry; a pop on an empty stack is ignored.
// Push and pop are never requested together.
module return_addr_stack
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ptr names the next slot to write; the top of stack sits just below it.
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr_prev;
  logic             full;

  assign ptr_prev = ptr - PTR_W'(1);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign top      = mem[ptr_prev];

  // Stack pointer and occupancy; the pointer wraps because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_prev;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-fetch-PC stage: holds the fetch PC, presents it to the BTB and I-fetch,
// and picks the following PC from the same-cycle BTB result, the return-address
// stack, or an execute redirect.
module fetch_pc_gen
  import bp_pkg::*;
#(
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = 30'h0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [FPC_W-1:0] fetch_PC,
  input  logic             hit,
  input  bt_e              btype,
  input  logic [PC_W-1:0]  target,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] seq_next;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_push_req;
  logic            ras_pop_req;
  logic            ras_push;
  logic            ras_pop;
  logic            fire;
  logic            pc_lsb_unused;

  // The word-within-block bit only travels with the PC; fetch works on blocks.
  assign fetch_PC      = pc_q[PC_W-1:1];
  assign pc_lsb_unused = pc_q[0];
  assign seq_next      = seq_pc(fetch_PC);
  assign fire          = fetch_valid & fetch_ready;

  // Next-PC selection from the BTB result for the current block.
  always_comb begin
    next_pc      = seq_next;
    ras_push_req = 1'b0;
    ras_pop_req  = 1'b0;
    if (hit) begin
      case (btype)
        BT_JUMP, BT_BRANCH: next_pc = target;
        BT_CALL: begin
          next_pc      = target;
          ras_push_req = 1'b1;
        end
        BT_RET: begin
          next_pc     = ras_empty ? target : ras_top;
          ras_pop_req = 1'b1;
        end
        default: next_pc = target;
      endcase
    end
  end

  // Stack updates follow accepted blocks only; a redirect discards this block's
  // update, and the stack is left as is (no repair of wrong-path pushes/pops).
  assign ras_push = fire & ~redirect_valid & ras_push_req;
  assign ras_pop  = fire & ~redirect_valid & ras_pop_req;

  assign pred_taken  = fetch_valid & hit;
  assign pred_target = next_pc;

  return_addr_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(seq_next),
    .top      (ras_top),
    .empty    (ras_empty)
  );

  // Fetch PC register: redirect beats an accepted request; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (fire) begin
      pc_q <= next_pc;
    end
  end

  // Request valid: low for the first cycle after reset, then held high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_valid <= 1'b0;
    else      fetch_valid <= 1'b1;
  end

endmodule
